// File: rtl/change_dispenser.sv
// Change dispenser: pays out an owed amount one note at a time, largest denomination
// first, from a six-entry note inventory, over a valid/ack handshake.
module change_dispenser (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] change_amount,
    input  logic       inv_load,
    input  logic [2:0] inv_sel,
    input  logic [7:0] inv_count,
    input  logic       note_ack,
    output logic       note_valid,
    output logic [2:0] note_denom,
    output logic [7:0] remaining_change,
    output logic       busy,
    output logic       dispense_done,
    output logic       dispense_error,
    output logic [2:0] dbg_state
);

    // Handshake: a note transfers on every rising edge where note_valid and note_ack
    // are both high; note_denom is stable while note_valid is high, and note_ack is
    // ignored while note_valid is low.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_ISSUE  = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [2:0] denom_q, denom_d;
    logic [7:0] inv_q [6];
    logic [7:0] inv_d [6];

    logic       pick_found;
    logic [2:0] pick_code;

    function automatic logic [7:0] denom_value(input logic [2:0] code);
        case (code)
            3'd0:    denom_value = 8'd1;
            3'd1:    denom_value = 8'd5;
            3'd2:    denom_value = 8'd10;
            3'd3:    denom_value = 8'd20;
            3'd4:    denom_value = 8'd50;
            3'd5:    denom_value = 8'd100;
            default: denom_value = 8'd0;
        endcase
    endfunction

    // Later (larger) codes override earlier ones, so the largest usable note wins.
    always_comb begin
        pick_found = 1'b0;
        pick_code  = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if ((rem_q >= denom_value(3'(i))) && (inv_q[i] != 8'd0)) begin
                pick_found = 1'b1;
                pick_code  = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        denom_d = denom_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                if (inv_load && (inv_sel < 3'd6)) begin
                    inv_d[inv_sel] = inv_count;
                end
                if (start) begin
                    rem_d   = change_amount;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q == 8'd0) begin
                    state_d = S_DONE;
                end else if (pick_found) begin
                    denom_d = pick_code;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_ISSUE: begin
                if (note_ack) begin
                    rem_d          = rem_q - denom_value(denom_q);
                    inv_d[denom_q] = inv_q[denom_q] - 8'd1;
                    state_d        = S_SELECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= 8'd0;
            denom_q <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                inv_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            denom_q <= denom_d;
            for (int i = 0; i < 6; i++) begin
                inv_q[i] <= inv_d[i];
            end
        end
    end

    assign note_valid       = (state_q == S_ISSUE);
    assign note_denom       = denom_q;
    assign remaining_change = rem_q;
    assign busy             = (state_q != S_IDLE);
    assign dispense_done    = (state_q == S_DONE);
    assign dispense_error   = (state_q == S_ERROR);
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized dispenses checked
// against a greedy payout model built from per-denomination note counts.
module tb_change_dispenser;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] change_amount;
    logic       inv_load;
    logic [2:0] inv_sel;
    logic [7:0] inv_count;
    logic       note_ack;
    logic       note_valid;
    logic [2:0] note_denom;
    logic [7:0] remaining_change;
    logic       busy;
    logic       dispense_done;
    logic       dispense_error;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    int         model_inv [6];
    logic [2:0] exp_q [$];

    change_dispenser dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .change_amount    (change_amount),
        .inv_load         (inv_load),
        .inv_sel          (inv_sel),
        .inv_count        (inv_count),
        .note_ack         (note_ack),
        .note_valid       (note_valid),
        .note_denom       (note_denom),
        .remaining_change (remaining_change),
        .busy             (busy),
        .dispense_done    (dispense_done),
        .dispense_error   (dispense_error),
        .dbg_state        (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int note_val(input int d);
        case (d)
            0: note_val = 1;
            1: note_val = 5;
            2: note_val = 10;
            3: note_val = 20;
            4: note_val = 50;
            5: note_val = 100;
            default: note_val = 0;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inventory(input string tag);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("%s_inv%0d", tag, i), 32'(dut.inv_q[i]), 32'(model_inv[i]));
        end
    endtask

    task automatic load_inv(input logic [2:0] sel, input logic [7:0] cnt);
        @(negedge clk);
        inv_load  = 1'b1;
        inv_sel   = sel;
        inv_count = cnt;
        @(negedge clk);
        inv_load  = 1'b0;
        if (sel < 3'd6) model_inv[sel] = int'(cnt);
    endtask

    task automatic load_all(input int c0, input int c1, input int c2,
                            input int c3, input int c4, input int c5);
        load_inv(3'd0, 8'(c0));
        load_inv(3'd1, 8'(c1));
        load_inv(3'd2, 8'(c2));
        load_inv(3'd3, 8'(c3));
        load_inv(3'd4, 8'(c4));
        load_inv(3'd5, 8'(c5));
    endtask

    // One dispense. Model: for each denomination largest-first take as many notes as
    // both the inventory and the remaining amount allow.
    task automatic run_txn(input logic [7:0] amt, input int min_stall, input int max_stall,
                           input bit noise, input bit ld, input logic [2:0] ld_sel,
                           input logic [7:0] ld_cnt);
        int         rem, take, exp_n, run_rem, c, stall, n_notes;
        bit         in_note, fin;
        logic [2:0] held_denom;
        logic [7:0] held_rem;
        logic [2:0] e;

        if (ld && ld_sel < 3'd6) model_inv[ld_sel] = int'(ld_cnt);
        exp_q.delete();
        rem = int'(amt);
        for (int d = 5; d >= 0; d--) begin
            take = rem / note_val(d);
            if (take > model_inv[d]) take = model_inv[d];
            for (int j = 0; j < take; j++) exp_q.push_back(3'(d));
            rem          -= take * note_val(d);
            model_inv[d] -= take;
        end
        exp_n   = exp_q.size();
        run_rem = int'(amt);

        @(negedge clk);
        start         = 1'b1;
        change_amount = amt;
        inv_load      = ld;
        inv_sel       = ld_sel;
        inv_count     = ld_cnt;
        @(negedge clk);
        start    = 1'b0;
        inv_load = 1'b0;
        c        = 1;
        check_eq("busy_k1", 32'(busy), 32'd1);
        check_eq("valid_k1", 32'(note_valid), 32'd0);

        fin     = 1'b0;
        in_note = 1'b0;
        n_notes = 0;
        stall   = 0;
        held_denom = 3'd0;
        held_rem   = 8'd0;
        while (!fin && c < 3000) begin
            start    = 1'b0;
            inv_load = 1'b0;
            if (dispense_done || dispense_error) begin
                check_eq("done", 32'(dispense_done), 32'(rem == 0));
                check_eq("error", 32'(dispense_error), 32'(rem != 0));
                check_eq("rem_final", 32'(remaining_change), 32'(rem));
                check_eq("note_count", 32'(n_notes), 32'(exp_n));
                if (max_stall == 0) check_eq("latency", 32'(c), 32'(2 * exp_n + 2));
                note_ack = 1'b0;
                fin      = 1'b1;
            end else if (note_valid) begin
                if (!in_note) begin
                    in_note    = 1'b1;
                    held_denom = note_denom;
                    held_rem   = remaining_change;
                    stall      = $urandom_range(min_stall, max_stall);
                    check_eq("rem_pre_note", 32'(remaining_change), 32'(run_rem));
                    if (exp_q.size() == 0) begin
                        check_eq("extra_note", 32'(note_denom), 32'd7);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("denom", 32'(note_denom), 32'(e));
                        run_rem -= note_val(int'(e));
                    end
                    n_notes++;
                end else begin
                    check_eq("denom_stable", 32'(note_denom), 32'(held_denom));
                    check_eq("rem_stable", 32'(remaining_change), 32'(held_rem));
                end
                if (stall == 0) begin
                    note_ack = 1'b1;
                    in_note  = 1'b0;
                end else begin
                    note_ack = 1'b0;
                    stall--;
                end
            end else begin
                if (in_note) check_eq("valid_stable", 32'(note_valid), 32'd1);
                in_note  = 1'b0;
                note_ack = 1'($urandom_range(0, 1));
            end
            if (noise && busy) begin
                start         = 1'($urandom_range(0, 1));
                change_amount = 8'($urandom_range(0, 255));
                inv_load      = 1'b1;
                inv_sel       = 3'($urandom_range(0, 7));
                inv_count     = 8'($urandom_range(0, 255));
            end
            if (!fin) begin
                @(negedge clk);
                c++;
            end
        end
        if (!fin) check_eq("timeout", 32'd0, 32'd1);

        start    = 1'b0;
        inv_load = 1'b0;
        note_ack = 1'b0;
        @(negedge clk);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("done_pulse", 32'(dispense_done | dispense_error), 32'd0);
        check_eq("rem_held", 32'(remaining_change), 32'(rem));
        check_inventory("post");
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        change_amount = 8'd0;
        inv_load      = 1'b0;
        inv_sel       = 3'd0;
        inv_count     = 8'd0;
        note_ack      = 1'b0;
        for (int i = 0; i < 6; i++) model_inv[i] = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(note_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(dispense_done), 32'd0);
        check_eq("rst_error", 32'(dispense_error), 32'd0);
        check_eq("rst_denom", 32'(note_denom), 32'd0);
        check_eq("rst_rem", 32'(remaining_change), 32'd0);
        check_inventory("rst");
        reset = 1'b1;

        load_all(10, 10, 10, 10, 10, 10);
        run_txn(8'd35, 0, 0, 1'b0, 1'b0, 3'd0, 8'd0);
        run_txn(8'd0, 0, 0, 1'b0, 1'b0, 3'd0, 8'd0);

        load_all(0, 0, 1, 3, 1, 0);
        run_txn(8'd120, 0, 0, 1'b0, 1'b0, 3'd0, 8'd0);

        load_all(3, 0, 0, 0, 0, 0);
        run_txn(8'd7, 0, 0, 1'b0, 1'b0, 3'd0, 8'd0);

        load_all(4, 4, 4, 4, 4, 4);
        load_inv(3'd6, 8'd99);
        load_inv(3'd7, 8'd99);
        run_txn(8'd35, 5, 5, 1'b0, 1'b0, 3'd0, 8'd0);
        run_txn(8'd187, 0, 2, 1'b1, 1'b0, 3'd0, 8'd0);
        run_txn(8'd230, 0, 0, 1'b0, 1'b1, 3'd5, 8'd2);

        // Reset while a note is pending: everything clears without a clock edge.
        load_all(10, 10, 10, 10, 10, 10);
        @(negedge clk);
        start         = 1'b1;
        change_amount = 8'd35;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_valid", 32'(note_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(note_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_denom", 32'(note_denom), 32'd0);
        check_eq("arst_rem", 32'(remaining_change), 32'd0);
        for (int i = 0; i < 6; i++) model_inv[i] = 0;
        check_inventory("arst");
        @(negedge clk);
        reset = 1'b1;
        load_all(0, 2, 2, 0, 0, 1);
        run_txn(8'd125, 0, 1, 1'b0, 1'b0, 3'd0, 8'd0);

        for (int t = 0; t < 25; t++) begin
            load_all($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
            run_txn(8'($urandom_range(0, 255)), 0, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 8'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Returns change to the customer after an overpayment. The payment controller supplies the change owed. The block then issues one note at a time to the mechanical note dispenser using a valid/ack handshake. It picks notes greedily, largest denomination first, from its own per-denomination inventory, and reports either completion or a shortfall.

## Interface
Parameters: none.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request to dispense. Sampled only in IDLE.
- `change_amount` in 8: change owed, in currency units. Captured with `start`.
- `inv_load` in 1: inventory write strobe. Honoured only in IDLE.
- `inv_sel` in 3: denomination code being written. Codes 6 and 7 are ignored.
- `inv_count` in 8: note count written into the selected counter.
- `note_ack` in 1: the dispenser has physically released the current note.
- `note_valid` out 1: a note request is pending.
- `note_denom` out 3: denomination code of the pending note.
- `remaining_change` out 8: change still owed.
- `busy` out 1: high in every state except IDLE.
- `dispense_done` out 1: one-cycle pulse; all change has been paid.
- `dispense_error` out 1: one-cycle pulse; inventory cannot cover the remainder.

## Operation
- Denomination codes and values: 0=1, 1=5, 2=10, 3=20, 4=50, 5=100.
- Inventory is six 8-bit counters, one per code. `inv_load` in IDLE overwrites the counter selected by `inv_sel` with `inv_count`.
- States:
  - IDLE.
    - `start`=1: capture `change_amount` into the remaining register, go to SELECT.
    - Otherwise stay.
  - SELECT (1 cycle).
    - remaining==0: go to DONE.
    - Otherwise, the largest denomination with value ≤ remaining and count > 0 is registered onto `note_denom`; go to ISSUE.
    - No such denomination: go to ERROR.
  - ISSUE.
    - `note_valid`=1, and `note_denom` is held stable.
    - On `note_ack`=1:
      - remaining -= value;
      - that denomination's count -= 1;
      - go to SELECT.
    - Without `note_ack`, stay indefinitely.
  - DONE: `dispense_done`=1 for this one cycle, then go to IDLE.
  - ERROR: `dispense_error`=1 for this one cycle, then go to IDLE. `remaining_change` keeps the shortfall.
- No rollback: notes already dispensed stay deducted from both inventory and remaining.
- Arithmetic:
  - The subtraction is 8-bit and cannot underflow, because value ≤ remaining is guaranteed by SELECT.
  - Counters cannot underflow, because count > 0 is guaranteed by SELECT.
- Greedy selection may report an error even where a non-greedy combination exists. This is accepted behaviour.
- `remaining_change` reflects the remaining register at all times. It is overwritten only by the next accepted `start`.
- `start` is ignored outside IDLE, and so is `inv_load`.
- In IDLE, `inv_load` and `start` in the same cycle: both take effect. Selection uses the updated count from the next cycle onward.

## Timing
- Reset (`reset`=0) sets:
  - state to IDLE;
  - `note_valid`, `busy`, `dispense_done`, `dispense_error` to 0;
  - `note_denom`=0;
  - `remaining_change`=0;
  - all inventory counters to 0.
- Reset takes effect immediately, including mid-dispense. A pending note request is dropped.
- All outputs are registered or decoded from state only (Moore). No input-to-output combinational path.
- `start` sampled at edge k:
  - `busy`=1 and SELECT from cycle k+1;
  - `note_valid`=1 from cycle k+2.
- Handshake:
  - A note transfers on any edge where `note_valid`=1 and `note_ack`=1.
  - `note_ack` may be asserted in the first cycle `note_valid` is high.
  - `note_valid` drops the cycle after the transfer edge.
  - `note_ack` outside ISSUE is ignored.
- Per note, minimum 2 cycles (ISSUE + SELECT).
- With zero-wait acks, N notes:
  - `dispense_done` high in cycle k+2N+2;
  - `busy` low from cycle k+2N+3.
- change_amount=0:
  - SELECT at k+1;
  - `dispense_done` at k+2;
  - no notes issued.

## Test plan
- Inventory 10 of each denomination, `start` with amount 35, ack held at 1: note sequence 20, 10, 5. `dispense_done` in cycle k+8, inventory 20/10/5 each end at 9, `remaining_change`=0.
- Amount 0: `dispense_done` at cycle k+2, `note_valid` never asserted.
- Inventory 100:0, 50:1, 20:3, 10:1, others 0; amount 120: notes 50, 20, 20, 20, 10, then done.
- Inventory 1:3 only; amount 7: three 1-notes, then a `dispense_error` pulse. `remaining_change`=4 stays held, and the code-0 count ends at 0.
- Ack stall: hold `note_ack` low 5 cycles during ISSUE. `note_valid` and `note_denom` stay stable, and `remaining_change` is unchanged until the ack.
- Assert `start`/`inv_load` while `busy`: both are ignored. Drive `reset` low during ISSUE: all outputs and inventory go to 0 asynchronously, and the block accepts a new `start` after release.
